// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: main + skid entry behind a valid/ready
// handshake. in_ready and out_valid decode straight from the state flops, so
// no combinational path exists from out_ready to in_ready. Synchronous flush
// squashes held entries. A saturating counter records back-pressured cycles.
module pipe_stage_elastic #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 144,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              flush,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_accept;
    logic                w_pop;
    logic                w_main_from_in;
    logic                w_main_from_skid;
    logic                w_skid_from_in;

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;

    // Next-state and register-load selects for the EMPTY/ONE/FULL occupancy FSM
    always_comb begin
        w_state_next     = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_main_from_in = 1'b1;
                    w_state_next   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_pop) begin
                    // Downstream stalled: park the new entry behind main.
                    w_skid_from_in = 1'b1;
                    w_state_next   = ST_FULL;
                end else if (w_accept && w_pop) begin
                    w_main_from_in = 1'b1;
                end else if (w_pop) begin
                    w_state_next   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_main_from_skid = 1'b1;
                    w_state_next     = ST_ONE;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // State and entry registers; flush empties the stage and bubbles the ctrl bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_main_from_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_main_from_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_skid_from_in) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    // Saturating back-pressure counter; clr_stats beats the increment, flush is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (clr_stats) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic: reset, streaming,
// back-pressure, flush in FULL, counter saturation, async reset mid-stream.
module tb_pipe_stage_elastic;

    localparam int CTRL_W = 9;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              clr_stats;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int checks;
    int errors;

    pipe_stage_elastic #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .clr_stats(clr_stats),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [CTRL_W-1:0] c,
                        input logic [DATA_W-1:0] d, input logic ordy);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
        $display("t=%0t in_v=%0b in_c=%h ordy=%0b flush=%0b clr=%0b -> out_v=%0b out_c=%h out_d=%h in_rdy=%0b stall=%0d",
                 $time, v, c, ordy, flush, clr_stats, out_valid, out_ctrl, out_data, in_ready, stall_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        clr_stats = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            in_ctrl   = CTRL_W'($urandom);
            in_data   = DATA_W'($urandom);
            out_ready = 1'($urandom);
            flush     = 1'($urandom);
            clr_stats = 1'($urandom);
            @(posedge clk);
            #1;
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_ctrl !== 9'h000) begin errors++; $display("FAIL reset_out_ctrl: got %h expected 000", out_ctrl); end
        checks++;
        if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        checks++;
        if (stall_cnt !== 4'h0) begin errors++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
        flush = 1'b0;
        clr_stats = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        // Idle after release: nothing valid offered, so nothing should appear.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 9'h0AA, 16'h1234, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || out_ctrl !== 9'h000 || stall_cnt !== 4'h0) begin
                errors++;
                $display("FAIL idle_after_reset: got v=%b c=%h s=%h expected v=0 c=000 s=0", out_valid, out_ctrl, stall_cnt);
            end
        end
    endtask

    task automatic test_streaming();
        logic [CTRL_W-1:0] ec;
        logic [DATA_W-1:0] ed;
        for (int i = 1; i <= 8; i++) begin
            ec = CTRL_W'(i);
            ed = DATA_W'(16'hA0 + i);
            step(1'b1, ec, ed, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== ec || out_data !== ed || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b c=%h d=%h rdy=%b expected v=1 c=%h d=%h rdy=1",
                         i, out_valid, out_ctrl, out_data, in_ready, ec, ed);
            end
        end
        step(1'b0, 9'h000, 16'h0000, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 9'h000) begin
            errors++; $display("FAIL stream_drain: got v=%b c=%h expected v=0 c=000", out_valid, out_ctrl);
        end
        checks++;
        if (stall_cnt !== 4'h0) begin errors++; $display("FAIL stream_stall_cnt: got %h expected 0", stall_cnt); end
    endtask

    task automatic test_back_pressure();
        // Entry 1 accepted into main; out_valid was 0 at this edge, so no stall yet.
        step(1'b1, 9'h001, 16'hB001, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_ctrl !== 9'h001 || stall_cnt !== 4'h0) begin
            errors++; $display("FAIL bp_c1: got v=%b rdy=%b c=%h s=%h expected v=1 rdy=1 c=001 s=0", out_valid, in_ready, out_ctrl, stall_cnt);
        end
        // Entry 2 goes to skid; stage is now full.
        step(1'b1, 9'h002, 16'hB002, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_ctrl !== 9'h001 || stall_cnt !== 4'h1) begin
            errors++; $display("FAIL bp_c2: got rdy=%b c=%h s=%h expected rdy=0 c=001 s=1", in_ready, out_ctrl, stall_cnt);
        end
        // Entry 3 held upstream for two more stalled cycles.
        step(1'b1, 9'h003, 16'hB003, 1'b0);
        step(1'b1, 9'h003, 16'hB003, 1'b0);
        checks++;
        if (stall_cnt !== 4'h3) begin errors++; $display("FAIL bp_stall_cnt: got %h expected 3", stall_cnt); end
        checks++;
        if (in_ready !== 1'b0 || out_ctrl !== 9'h001 || out_data !== 16'hB001) begin
            errors++; $display("FAIL bp_out1: got rdy=%b c=%h d=%h expected rdy=0 c=001 d=B001", in_ready, out_ctrl, out_data);
        end
        // Release: pop entry 1, skid moves to main.
        step(1'b1, 9'h003, 16'hB003, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 9'h002 || out_data !== 16'hB002 || in_ready !== 1'b1 || stall_cnt !== 4'h3) begin
            errors++; $display("FAIL bp_out2: got v=%b c=%h d=%h rdy=%b s=%h expected v=1 c=002 d=B002 rdy=1 s=3",
                               out_valid, out_ctrl, out_data, in_ready, stall_cnt);
        end
        // Pop entry 2 while entry 3 is accepted.
        step(1'b1, 9'h003, 16'hB003, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 9'h003 || out_data !== 16'hB003) begin
            errors++; $display("FAIL bp_out3: got v=%b c=%h d=%h expected v=1 c=003 d=B003", out_valid, out_ctrl, out_data);
        end
        step(1'b0, 9'h000, 16'h0000, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 9'h000) begin
            errors++; $display("FAIL bp_drain: got v=%b c=%h expected v=0 c=000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_flush_full();
        step(1'b1, 9'h011, 16'hC011, 1'b0);
        step(1'b1, 9'h012, 16'hC012, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill: got rdy=%b expected 0", in_ready); end
        flush = 1'b1;
        step(1'b1, 9'h1FF, 16'hCFFF, 1'b0);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 9'h000 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_result: got v=%b c=%h rdy=%b expected v=0 c=000 rdy=1", out_valid, out_ctrl, in_ready);
        end
        // Next upstream entry is accepted normally; the squashed 0x1FF never surfaces.
        step(1'b1, 9'h021, 16'hC021, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 9'h021 || out_data !== 16'hC021) begin
            errors++; $display("FAIL flush_after: got v=%b c=%h d=%h expected v=1 c=021 d=C021", out_valid, out_ctrl, out_data);
        end
        step(1'b0, 9'h000, 16'h0000, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 9'h000) begin
            errors++; $display("FAIL flush_drain: got v=%b c=%h expected v=0 c=000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_counter_saturation();
        clr_stats = 1'b1;
        step(1'b0, 9'h000, 16'h0000, 1'b1);
        clr_stats = 1'b0;
        checks++;
        if (stall_cnt !== 4'h0) begin errors++; $display("FAIL sat_clear0: got %h expected 0", stall_cnt); end
        step(1'b1, 9'h005, 16'hD005, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 9'h000, 16'h0000, 1'b0);
            if (i == 14) begin
                checks++;
                if (stall_cnt !== 4'hE) begin errors++; $display("FAIL sat_count14: got %h expected E", stall_cnt); end
            end
        end
        checks++;
        if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h expected F", stall_cnt); end
        clr_stats = 1'b1;
        step(1'b0, 9'h000, 16'h0000, 1'b0);
        clr_stats = 1'b0;
        checks++;
        if (stall_cnt !== 4'h0) begin errors++; $display("FAIL sat_clr_wins: got %h expected 0", stall_cnt); end
        step(1'b0, 9'h000, 16'h0000, 1'b0);
        checks++;
        if (stall_cnt !== 4'h1) begin errors++; $display("FAIL sat_restart: got %h expected 1", stall_cnt); end
        step(1'b0, 9'h000, 16'h0000, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'h1) begin
            errors++; $display("FAIL sat_pop: got v=%b s=%h expected v=0 s=1", out_valid, stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 9'h031, 16'hE031, 1'b0);
        step(1'b1, 9'h032, 16'hE032, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_ctrl !== 9'h031) begin
            errors++; $display("FAIL arst_prefill: got rdy=%b c=%h expected rdy=0 c=031", in_ready, out_ctrl);
        end
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 9'h000 || out_data !== 16'h0000 || stall_cnt !== 4'h0) begin
            errors++; $display("FAIL arst_immediate: got v=%b rdy=%b c=%h d=%h s=%h expected v=0 rdy=1 c=000 d=0000 s=0",
                               out_valid, in_ready, out_ctrl, out_data, stall_cnt);
        end
        #1;
        rst = 1'b1;
        step(1'b1, 9'h041, 16'hE041, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 9'h041 || out_data !== 16'hE041) begin
            errors++; $display("FAIL arst_restart1: got v=%b c=%h d=%h expected v=1 c=041 d=E041", out_valid, out_ctrl, out_data);
        end
        step(1'b1, 9'h042, 16'hE042, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 9'h042 || out_data !== 16'hE042) begin
            errors++; $display("FAIL arst_restart2: got v=%b c=%h d=%h expected v=1 c=042 d=E042", out_valid, out_ctrl, out_data);
        end
        step(1'b0, 9'h000, 16'h0000, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 9'h000) begin
            errors++; $display("FAIL arst_drain: got v=%b c=%h expected v=0 c=000", out_valid, out_ctrl);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        clr_stats = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_full();
        test_counter_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
